// File: rtl/factor_display_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : factor_display_sequencer
// Purpose  : Sequences one factorization per input number and then steps the
//            seven-segment digit stream through 1 and every divisor in 2..9.
//            Each digit is held for DWELL_COUNT cycles, and the hold can be
//            frozen with pause.
// Ports    : clk          - system clock
//            reset        - synchronous, active-high reset
//            number       - value to factorize (switches)
//            pause        - freeze the current digit and its dwell count
//            fact_start   - one-cycle launch pulse to the factorizer
//            fact_number  - operand presented to the factorizer
//            fact_done    - factorizer result valid (single-cycle pulse)
//            fact_factors - divisor mask, bit i set => (i+2) divides operand
//            factors      - latched divisor mask
//            digit        - digit to display (0, or 1..9)
//            digit_valid  - digit holds a meaningful value
//            busy         - factorization in progress (LAUNCH or WAIT)
// Revision : 1.0 - initial release
// ============================================================================
module factor_display_sequencer #(
    parameter int DWELL_COUNT    = 10_000_000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] number,
    input  logic       pause,
    output logic       fact_start,
    output logic [6:0] fact_number,
    input  logic       fact_done,
    input  logic [7:0] fact_factors,
    output logic [7:0] factors,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       busy
);

    localparam int c_DW = (DWELL_COUNT > 1) ? $clog2(DWELL_COUNT) : 1;
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_COUNT - 1);
    localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_LAUNCH = 3'd1;
    localparam logic [2:0] c_ST_WAIT   = 3'd2;
    localparam logic [2:0] c_ST_SHOW   = 3'd3;
    localparam logic [2:0] c_ST_SCAN   = 3'd4;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]      r_state;
    logic            r_fact_start;
    logic [6:0]      r_fact_number;
    logic [7:0]      r_factors;
    logic [3:0]      r_digit;
    logic            r_digit_valid;
    logic            r_busy;
    logic [c_DW-1:0] r_dwell;
    logic [c_TW-1:0] r_tmo;
    logic [3:0]      r_cand;
    // Set when the display came from the number<2 path. fact_number is not
    // refreshed on that path, so change detection must not compare against it.
    logic            r_small;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [2:0]      w_state_nxt;
    logic            w_fact_start_nxt;
    logic [6:0]      w_fact_number_nxt;
    logic [7:0]      w_factors_nxt;
    logic [3:0]      w_digit_nxt;
    logic            w_digit_valid_nxt;
    logic            w_busy_nxt;
    logic [c_DW-1:0] w_dwell_nxt;
    logic [c_TW-1:0] w_tmo_nxt;
    logic [3:0]      w_cand_nxt;
    logic            w_small_nxt;

    logic            w_changed;
    logic [15:0]     w_div_map;

    // Input number no longer matches what is being displayed.
    assign w_changed = r_small ? (number >= 7'd2) : (number != r_fact_number);

    // Divisor map indexed directly by candidate value: bit k set => k divides
    // the operand. Only indices 2..9 are ever consulted.
    assign w_div_map = {6'b000000, r_factors, 2'b00};

    always_comb begin
        w_state_nxt       = r_state;
        w_fact_start_nxt  = 1'b0;
        w_fact_number_nxt = r_fact_number;
        w_factors_nxt     = r_factors;
        w_digit_nxt       = r_digit;
        w_digit_valid_nxt = r_digit_valid;
        w_dwell_nxt       = r_dwell;
        w_tmo_nxt         = r_tmo;
        w_cand_nxt        = r_cand;
        w_small_nxt       = r_small;

        case (r_state)
            c_ST_IDLE: begin
                if (number < 7'd2) begin
                    w_state_nxt       = c_ST_SHOW;
                    w_factors_nxt     = 8'h00;
                    w_digit_nxt       = 4'd1;
                    w_digit_valid_nxt = 1'b1;
                    w_dwell_nxt       = '0;
                    w_small_nxt       = 1'b1;
                end else begin
                    // Operand is captured here so it is already stable in
                    // the cycle where fact_start is high.
                    w_state_nxt       = c_ST_LAUNCH;
                    w_fact_start_nxt  = 1'b1;
                    w_fact_number_nxt = number;
                    w_small_nxt       = 1'b0;
                end
            end

            c_ST_LAUNCH: begin
                w_tmo_nxt   = '0;
                w_state_nxt = c_ST_WAIT;
            end

            c_ST_WAIT: begin
                if (w_changed) begin
                    // A change in the same cycle as fact_done discards it.
                    w_state_nxt       = c_ST_IDLE;
                    w_digit_nxt       = 4'd0;
                    w_digit_valid_nxt = 1'b0;
                end else if (fact_done) begin
                    w_state_nxt       = c_ST_SHOW;
                    w_factors_nxt     = fact_factors;
                    w_digit_nxt       = 4'd1;
                    w_digit_valid_nxt = 1'b1;
                    w_dwell_nxt       = '0;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_state_nxt       = c_ST_SHOW;
                    w_factors_nxt     = 8'h00;
                    w_digit_nxt       = 4'd1;
                    w_digit_valid_nxt = 1'b1;
                    w_dwell_nxt       = '0;
                end else begin
                    w_tmo_nxt = r_tmo + c_TW'(1);
                end
            end

            c_ST_SHOW: begin
                if (w_changed) begin
                    w_state_nxt       = c_ST_IDLE;
                    w_digit_nxt       = 4'd0;
                    w_digit_valid_nxt = 1'b0;
                end else if (!pause) begin
                    if (r_dwell == c_DWELL_LAST) begin
                        w_dwell_nxt = '0;
                        w_cand_nxt  = r_digit + 4'd1;
                        w_state_nxt = c_ST_SCAN;
                    end else begin
                        w_dwell_nxt = r_dwell + c_DW'(1);
                    end
                end
            end

            c_ST_SCAN: begin
                // The old digit stays on the display while candidates are
                // walked one per cycle; these cycles do not count as dwell.
                if (w_changed) begin
                    w_state_nxt       = c_ST_IDLE;
                    w_digit_nxt       = 4'd0;
                    w_digit_valid_nxt = 1'b0;
                end else if (r_cand > 4'd9) begin
                    w_digit_nxt = 4'd1;
                    w_state_nxt = c_ST_SHOW;
                end else if (w_div_map[r_cand]) begin
                    w_digit_nxt = r_cand;
                    w_state_nxt = c_ST_SHOW;
                end else begin
                    w_cand_nxt = r_cand + 4'd1;
                end
            end

            default: begin
                w_state_nxt       = c_ST_IDLE;
                w_digit_nxt       = 4'd0;
                w_digit_valid_nxt = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == c_ST_LAUNCH) || (w_state_nxt == c_ST_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_fact_start  <= 1'b0;
            r_fact_number <= 7'd0;
            r_factors     <= 8'h00;
            r_digit       <= 4'd0;
            r_digit_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_dwell       <= '0;
            r_tmo         <= '0;
            r_cand        <= 4'd0;
            r_small       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fact_start  <= w_fact_start_nxt;
            r_fact_number <= w_fact_number_nxt;
            r_factors     <= w_factors_nxt;
            r_digit       <= w_digit_nxt;
            r_digit_valid <= w_digit_valid_nxt;
            r_busy        <= w_busy_nxt;
            r_dwell       <= w_dwell_nxt;
            r_tmo         <= w_tmo_nxt;
            r_cand        <= w_cand_nxt;
            r_small       <= w_small_nxt;
        end
    end

    assign fact_start  = r_fact_start;
    assign fact_number = r_fact_number;
    assign factors     = r_factors;
    assign digit       = r_digit;
    assign digit_valid = r_digit_valid;
    assign busy        = r_busy;

endmodule
`default_nettype wire
